hps_data_out_fifo_reader: RTL
=============================

Name: hps_data_out_fifo_reader

Overview:
- Fabric-to-HPS input port; the counterpart of the HPS-written output register port.
- Fabric logic pushes 32-bit words over a valid/ready stream into an on-chip FIFO.
- The HPS drains the FIFO and polls status through a 4-word Avalon-MM slave with read latency 0.
- A level interrupt is raised on not-empty, threshold or overflow conditions, each individually masked.

Parameters:
- DATA_W, 32, stream and register data width (fixed 32 for the Avalon map).
- DEPTH, 16, FIFO depth in words; power of two, range 2..128.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational (latency 0).
- irq  out  1  level interrupt, registered.
- in_data  in  DATA_W  fabric stream word.
- in_valid  in  1  fabric word valid.
- in_ready  out  1  equals ~full.

Behaviour:
- Reset: FIFO empty, count=0, sticky flags=0, mask=0, threshold=0, irq=0, in_ready=1, readdata=0.
- Register map:
  - 0 DATA (R): returns the head word. A read with chipselect & ~read_n pops the head in that cycle. A read when empty returns 0, does not pop, and sets UNDERFLOW.
  - 1 STATUS (R/W1C): bit0 empty, bit1 full, bit2 OVERFLOW, bit3 UNDERFLOW, bits[15:8] count (zero-extended), all other bits 0. Writing 1 to bit2 or bit3 clears that flag.
  - 2 IRQ_CFG (RW): bit0 NE_EN, bit1 THR_EN, bit2 OVF_EN, bits[15:8] threshold. Reads return the stored value.
  - 3 CONTROL (W): bit0 FLUSH, self-clearing. Reads return 0.
- Push: occurs when in_valid & in_ready; the word is visible at DATA on the next cycle.
- Full: in_valid while full sets OVERFLOW. The source is not required to hold its word; that word is dropped.
- Pop and push in the same cycle (not empty, not full): count unchanged, ordering preserved.
- Push while empty and DATA read in the same cycle: the read returns 0 and sets UNDERFLOW; the pushed word is retained (count becomes 1).
- Flush: pointers and count go to 0 on the next edge.
  - A push in the flush cycle is discarded and does not set OVERFLOW.
  - Sticky flags and IRQ_CFG are unaffected.
- Sticky flag set event and W1C in the same cycle: set wins.
- Pointers wrap modulo DEPTH. Count runs 0..DEPTH; full = (count == DEPTH).
- irq is registered: irq <= (NE_EN & ~empty) | (THR_EN & count >= threshold & threshold != 0) | (OVF_EN & OVERFLOW). It uses the state after the current edge's updates, giving 1 cycle of latency from the causing event.
- Writes to address 0 are ignored.
- Access without chipselect has no side effects; readdata = 0.
- Asynchronous reset mid-transfer: FIFO contents are discarded, and all state returns to reset values immediately.

Decomposition:
- Package hps_data_out_fifo_pkg holds:
  - Register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_IRQ_CFG=2, ADDR_CONTROL=3.
  - STATUS and IRQ_CFG bit-position constants.
  - Field widths for count and threshold (8).
- One sub-module, hps_sync_fifo:
  - Parameterised DATA_W/DEPTH, register-array storage.
  - Ports push, pop, flush, din, dout (head, show-ahead), count, empty, full.
- The top level contains the Avalon decode, sticky flags, IRQ_CFG register and irq logic.

Test Plan:
- Reset, push 0xA5A5_0001..0xA5A5_0003, read DATA three times -> returns in order; STATUS then reads empty=1, count=0.
- Push 16 words with in_valid held -> in_ready=0 after the 16th push, full=1, count=16. A 17th in_valid pulse -> OVERFLOW=1, word dropped; draining returns only the first 16 words. Write STATUS 0x4 -> OVERFLOW=0.
- Read DATA while empty with a push in the same cycle -> readdata=0, UNDERFLOW=1, count=1; the next DATA read returns the pushed word.
- IRQ_CFG = threshold 4 with THR_EN -> irq=0 at count 3; irq=1 the cycle after the 4th push; one DATA read -> irq=0 the following cycle.
- Fill 5 words, write CONTROL=1 with a concurrent push -> count=0, empty=1, OVERFLOW unchanged, discarded word never read.
- Continuous push and pop for 40 words with DEPTH=16 -> pointer wrap verified, data order intact, count stays constant throughout.

Source files
------------

// File: rtl/hps_data_out_fifo_pkg.sv
// Shared constants and types for the fabric-to-HPS FIFO reader port.
// Holds the register address map, STATUS / IRQ_CFG bit positions,
// field widths, and pack/unpack helpers for the IRQ_CFG register.
package hps_data_out_fifo_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_IRQ_CFG = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_UDF_BIT    = 3;
  localparam int ST_COUNT_LSB  = 8;

  // IRQ_CFG bit positions
  localparam int CFG_NE_EN_BIT  = 0;
  localparam int CFG_THR_EN_BIT = 1;
  localparam int CFG_OVF_EN_BIT = 2;
  localparam int CFG_THR_LSB    = 8;

  // CONTROL bit positions
  localparam int CTL_FLUSH_BIT = 0;

  // Field widths
  localparam int COUNT_W = 8;
  localparam int THR_W   = 8;

  typedef struct packed {
    logic [THR_W-1:0] threshold;
    logic             ovf_en;
    logic             thr_en;
    logic             ne_en;
  } irq_cfg_t;

  function automatic logic [31:0] pack_irq_cfg(input irq_cfg_t c);
    logic [31:0] r;
    r = '0;
    r[CFG_NE_EN_BIT]             = c.ne_en;
    r[CFG_THR_EN_BIT]            = c.thr_en;
    r[CFG_OVF_EN_BIT]            = c.ovf_en;
    r[CFG_THR_LSB +: THR_W]      = c.threshold;
    return r;
  endfunction

  function automatic irq_cfg_t unpack_irq_cfg(input logic [31:0] w);
    irq_cfg_t c;
    c.ne_en     = w[CFG_NE_EN_BIT];
    c.thr_en    = w[CFG_THR_EN_BIT];
    c.ovf_en    = w[CFG_OVF_EN_BIT];
    c.threshold = w[CFG_THR_LSB +: THR_W];
    return c;
  endfunction

endpackage

// File: rtl/hps_sync_fifo.sv
// Single-clock show-ahead FIFO with register-array storage and flush.
// Ports: clk/reset_n; push, pop, flush controls; din in; dout (head word),
// count (0..DEPTH), empty, full out. Push when full / pop when empty are ignored.
module hps_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign dout  = mem[rd_ptr];

  // Flush takes priority over any same-cycle push or pop.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage is not reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so
      // the increment wraps modulo DEPTH on its own.
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hps_data_out_fifo_reader.sv
// Fabric-to-HPS input port: fabric stream words are queued in a FIFO that
// the HPS drains through a 4-word Avalon-MM slave (read latency 0).
// Ports: clk, reset_n; Avalon address/chipselect/read_n/write_n/writedata/
// readdata; irq (registered level); fabric in_data/in_valid/in_ready.
module hps_data_out_fifo_reader
  import hps_data_out_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic              rd_en;
  logic              wr_en;
  logic              data_rd;
  logic              push;
  logic              pop;
  logic              flush;
  logic              ovf_set;
  logic              udf_set;
  logic              ovf_clr;
  logic              udf_clr;
  logic              ovf_q;
  logic              udf_q;
  logic              ovf_d;
  logic              udf_d;
  irq_cfg_t          cfg_q;
  irq_cfg_t          cfg_d;
  logic              irq_d;
  logic [PTR_W:0]    count_nxt;
  logic [COUNT_W-1:0] count8_nxt;
  logic              empty_nxt;
  logic [31:0]       status;

  logic [DATA_W-1:0] fifo_dout;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic              unused_wdata;
  assign unused_wdata = ^{writedata[31:16], writedata[7:4]};

  assign rd_en   = chipselect & ~read_n;
  assign wr_en   = chipselect & ~write_n;
  assign data_rd = rd_en & (address == ADDR_DATA);
  assign flush   = wr_en & (address == ADDR_CONTROL) & writedata[CTL_FLUSH_BIT];

  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full & ~flush;
  assign pop      = data_rd & ~fifo_empty;

  // A word offered while full is dropped; during a flush the word is simply
  // discarded with the rest of the queue and is not an overflow.
  assign ovf_set = in_valid & fifo_full & ~flush;
  assign udf_set = data_rd & fifo_empty;
  assign ovf_clr = wr_en & (address == ADDR_STATUS) & writedata[ST_OVF_BIT];
  assign udf_clr = wr_en & (address == ADDR_STATUS) & writedata[ST_UDF_BIT];

  hps_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (in_data),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Next-state view used by the registered irq, so irq reflects the state
  // produced by this edge (one cycle after the causing event).
  always_comb begin
    count_nxt = fifo_count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = fifo_count + CNT_ONE;
        2'b01:   count_nxt = fifo_count - CNT_ONE;
        default: count_nxt = fifo_count;
      endcase
    end
    count8_nxt = COUNT_W'(count_nxt);
    empty_nxt  = (count_nxt == '0);

    // Set beats a same-cycle write-1-to-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    udf_d = (udf_q & ~udf_clr) | udf_set;

    cfg_d = cfg_q;
    if (wr_en && (address == ADDR_IRQ_CFG)) cfg_d = unpack_irq_cfg(writedata);

    irq_d = (cfg_d.ne_en & ~empty_nxt)
          | (cfg_d.thr_en & (cfg_d.threshold != '0) & (count8_nxt >= cfg_d.threshold))
          | (cfg_d.ovf_en & ovf_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      cfg_q <= '0;
      irq   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      cfg_q <= cfg_d;
      irq   <= irq_d;
    end
  end

  always_comb begin
    status = '0;
    status[ST_EMPTY_BIT]              = fifo_empty;
    status[ST_FULL_BIT]               = fifo_full;
    status[ST_OVF_BIT]                = ovf_q;
    status[ST_UDF_BIT]                = udf_q;
    status[ST_COUNT_LSB +: COUNT_W]   = COUNT_W'(fifo_count);
  end

  // Latency-0 read mux; idle or deselected bus reads as zero.
  always_comb begin
    readdata = '0;
    if (rd_en) begin
      unique case (address)
        ADDR_DATA:    readdata = fifo_empty ? '0 : 32'(fifo_dout);
        ADDR_STATUS:  readdata = status;
        ADDR_IRQ_CFG: readdata = pack_irq_cfg(cfg_q);
        default:      readdata = '0;
      endcase
    end
  end

endmodule
